// File: rtl/diad_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package diad_loader_pkg;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        VERIFY,
        DONE,
        ERR
    } ldr_state_t;

    // Frame start marker, only meaningful outside a frame
    localparam logic [7:0] LDR_SYNC = 8'hA5;

    // Number of bytes needed to carry one instruction word
    function automatic int ldr_bpw(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/ldr_word_asm.sv
// Byte-to-word assembler: shifts bytes in MSB-first and flags the byte that
// completes a word. The assembled word is presented combinationally so the
// caller can capture it on the same edge that accepts the final byte.
module ldr_word_asm
    import diad_loader_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_complete
);

    localparam int BPW   = ldr_bpw(DATA_W);
    localparam int SH_W  = BPW * 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [SH_W-1:0]  sh_q;
    logic [SH_W-1:0]  sh_next;
    logic [CNT_W-1:0] cnt_q;

    assign sh_next       = (sh_q << 8) | SH_W'(byte_in);
    assign word          = sh_next[DATA_W-1:0];
    assign word_complete = shift_en && (cnt_q == LAST);

    // Byte position within the current word; restarts on every new frame
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= word_complete ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Shift register holding the partially assembled word
    always_ff @(posedge iw_clk) begin
        if (shift_en) begin
            sh_q <= sh_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (sync, 16-bit word count, payload,
// XOR checksum), writes the words to instruction memory port 1 starting at
// BASE_ADDR, and releases the core reset only after a good checksum.
// Defining IMEM_LOADER_VERIFY_EN adds a readback pass over the written words
// before the core is released.
module imem_loader
    import diad_loader_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_byte_valid,
    input  logic [7:0]        iw_byte,
    output logic              ow_byte_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_core_rst,
    output logic              ow_done,
    output logic              ow_err
);

    ldr_state_t        state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [15:0]       wcnt_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              core_rst_q;
    logic              done_q;
    logic              err_q;

    logic              acc;
    logic              sync_start;
    logic              shift_en;
    logic              word_complete;
    logic              enter_verify;
    logic              good_csum;
    logic [DATA_W-1:0] asm_word;

    assign ow_byte_ready = (state_q != VERIFY);
    assign acc           = iw_byte_valid && ow_byte_ready;
    assign sync_start    = acc && (iw_byte == LDR_SYNC) &&
                           (state_q inside {IDLE, DONE, ERR});
    assign shift_en      = acc && (state_q == DATA);
    assign good_csum     = (iw_byte == csum_q);

    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_core_rst  = core_rst_q;
    assign ow_done      = done_q;
    assign ow_err       = err_q;

    ldr_word_asm #(
        .DATA_W(DATA_W)
    ) u_word_asm (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .clear        (sync_start),
        .shift_en     (shift_en),
        .byte_in      (iw_byte),
        .word         (asm_word),
        .word_complete(word_complete)
    );

`ifdef IMEM_LOADER_VERIFY_EN
    localparam int BPW  = ldr_bpw(DATA_W);
    localparam int SH_W = BPW * 8;

    logic [15:0] vcnt_q;
    logic [7:0]  rb_xor_q;
    logic [7:0]  rb_final;

    // XOR of all bytes of a word, matching how the sender built the checksum
    function automatic logic [7:0] fold_bytes(input logic [DATA_W-1:0] w);
        logic [SH_W-1:0] x;
        logic [7:0]      r;
        x = SH_W'(w);
        r = '0;
        for (int i = 0; i < BPW; i++) begin
            r = r ^ x[i*8 +: 8];
        end
        return r;
    endfunction

    assign rb_final     = rb_xor_q ^ fold_bytes(iw_mem_rdata);
    assign enter_verify = (state_q == CSUM) && (state_d == VERIFY);

    // Readback pass: cycle k issues address k, data for k-1 arrives alongside
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            vcnt_q   <= '0;
            rb_xor_q <= '0;
        end else if (enter_verify) begin
            vcnt_q   <= '0;
            rb_xor_q <= '0;
        end else if (state_q == VERIFY) begin
            vcnt_q <= vcnt_q + 16'd1;
            if (vcnt_q != 16'd0) begin
                rb_xor_q <= rb_final;
            end
        end
    end
`else
    logic rdata_unused;
    assign rdata_unused = ^iw_mem_rdata;
    assign enter_verify = 1'b0;
`endif

    // Next-state decode for the frame parser
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (sync_start) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (acc) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (acc) state_d = ({len_hi_q, iw_byte} != 16'd0) ? DATA : CSUM;
            end
            DATA: begin
                if (word_complete && ((wcnt_q + 16'd1) == len_q)) state_d = CSUM;
            end
            CSUM: begin
                if (acc) begin
`ifdef IMEM_LOADER_VERIFY_EN
                    if (!good_csum)          state_d = ERR;
                    else if (len_q == 16'd0) state_d = DONE;
                    else                     state_d = VERIFY;
`else
                    state_d = good_csum ? DONE : ERR;
`endif
                end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            VERIFY: begin
                if (vcnt_q == len_q) state_d = (rb_final == csum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control: state, write strobe, address walk and load status
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csum_q     <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= word_complete;
            if (word_complete) begin
                wdata_q <= asm_word;
            end

            if (sync_start || enter_verify) begin
                addr_q <= BASE_ADDR;
            end else if (we_q || (state_q == VERIFY)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (sync_start) begin
                csum_q <= '0;
                wcnt_q <= '0;
            end else begin
                if (shift_en)      csum_q <= csum_q ^ iw_byte;
                if (word_complete) wcnt_q <= wcnt_q + 16'd1;
            end

            if (sync_start) begin
                core_rst_q <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else if (state_d == DONE) begin
                core_rst_q <= 1'b0;
                done_q     <= 1'b1;
            end else if (state_d == ERR) begin
                err_q      <= 1'b1;
            end
        end
    end

    // Frame length capture
    always_ff @(posedge iw_clk) begin
        if (acc && (state_q == LEN_HI)) len_hi_q <= iw_byte;
        if (acc && (state_q == LEN_LO)) len_q    <= {len_hi_q, iw_byte};
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (DATA_W=24, ADDR_W=24, BASE_ADDR=0).
// Expected memory writes are queued as the frame bytes are driven and popped
// by a write monitor. The readback test runs when IMEM_LOADER_VERIFY_EN is set.
module tb_imem_loader;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 24;

    logic              iw_clk;
    logic              iw_rst;
    logic              iw_byte_valid;
    logic [7:0]        iw_byte;
    logic              ow_byte_ready;
    logic              ow_mem_we;
    logic [ADDR_W-1:0] ow_mem_addr;
    logic [DATA_W-1:0] ow_mem_wdata;
    logic [DATA_W-1:0] iw_mem_rdata;
    logic              ow_core_rst;
    logic              ow_done;
    logic              ow_err;

    int checks;
    int errors;

    logic [47:0] exp_q[$];
    logic [23:0] words[0:3];
    logic [23:0] mem[0:15];
    logic        corrupt;
    logic        we_prev;

    imem_loader #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(24'h0)
    ) dut (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_byte_valid(iw_byte_valid),
        .iw_byte      (iw_byte),
        .ow_byte_ready(ow_byte_ready),
        .ow_mem_we    (ow_mem_we),
        .ow_mem_addr  (ow_mem_addr),
        .ow_mem_wdata (ow_mem_wdata),
        .iw_mem_rdata (iw_mem_rdata),
        .ow_core_rst  (ow_core_rst),
        .ow_done      (ow_done),
        .ow_err       (ow_err)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    // Memory model with one-cycle read latency; can corrupt word 1 on read
    always @(posedge iw_clk) begin
        if (ow_mem_we) mem[ow_mem_addr[3:0]] <= ow_mem_wdata;
        iw_mem_rdata <= mem[ow_mem_addr[3:0]] ^
                        ((corrupt && ow_mem_addr == 24'd1) ? 24'h000001 : 24'h000000);
    end

    // Write monitor: every write pulse must match the next queued expectation
    always @(negedge iw_clk) begin
        logic [47:0] e;
        if (iw_rst) begin
            we_prev = 1'b0;
        end else begin
            if (ow_mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected addr=%h data=%h", ow_mem_addr, ow_mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({ow_mem_addr, ow_mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL write_value got addr=%h data=%h want addr=%h data=%h",
                                 ow_mem_addr, ow_mem_wdata, e[47:24], e[23:0]);
                    end
                end
                checks++;
                if (we_prev) begin
                    errors++;
                    $display("FAIL we_pulse_width we high on consecutive cycles addr=%h", ow_mem_addr);
                end
            end
            we_prev = ow_mem_we;
        end
    end

    // Drive one byte, holding it until accepted (called at a negedge)
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        iw_byte       = b;
        iw_byte_valid = 1'b1;
        while (!ow_byte_ready && n < 100) begin
            @(negedge iw_clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL ready_timeout got ready=%b want 1", ow_byte_ready);
        end
        @(posedge iw_clk);
        @(negedge iw_clk);
        iw_byte_valid = 1'b0;
    endtask

    // Send a frame of n words from words[], optional idle gap before each data byte
    task automatic send_frame(input int n, input bit bad, input bit gap);
        logic [7:0] csum;
        logic [7:0] b;
        csum = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                b    = words[i][23 - 8*k -: 8];
                csum = csum ^ b;
                if (k == 2) exp_q.push_back({24'(i), words[i]});
                if (gap) @(negedge iw_clk);
                send_byte(b);
            end
        end
        send_byte(csum ^ (bad ? 8'h01 : 8'h00));
    endtask

    // Bounded wait for the loader to report completion or failure
    task automatic wait_end();
        int n;
        n = 0;
        while (!(ow_done || ow_err) && n < 50) begin
            @(negedge iw_clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL end_timeout got done=%b err=%b want one set", ow_done, ow_err);
        end
    endtask

    task automatic test_reset();
        iw_rst = 1'b1;
        repeat (2) @(negedge iw_clk);
        checks += 7;
        if (ow_mem_we !== 1'b0)      begin errors++; $display("FAIL reset_we got %b want 0", ow_mem_we); end
        if (ow_mem_addr !== 24'h0)   begin errors++; $display("FAIL reset_addr got %h want 0", ow_mem_addr); end
        if (ow_mem_wdata !== 24'h0)  begin errors++; $display("FAIL reset_wdata got %h want 0", ow_mem_wdata); end
        if (ow_core_rst !== 1'b1)    begin errors++; $display("FAIL reset_core_rst got %b want 1", ow_core_rst); end
        if (ow_done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", ow_done); end
        if (ow_err !== 1'b0)         begin errors++; $display("FAIL reset_err got %b want 0", ow_err); end
        if (ow_byte_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b want 1", ow_byte_ready); end
        iw_rst = 1'b0;
        @(negedge iw_clk);
    endtask

    task automatic test_garbage();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        checks += 2;
        if (ow_done !== 1'b0 || ow_core_rst !== 1'b1) begin
            errors++; $display("FAIL garbage_idle got done=%b core_rst=%b want 0 1", ow_done, ow_core_rst);
        end
        if (ow_mem_addr !== 24'h0) begin errors++; $display("FAIL garbage_addr got %h want 0", ow_mem_addr); end
        send_frame(0, 1'b0, 1'b0);
        wait_end();
        checks += 2;
        if (ow_done !== 1'b1 || ow_err !== 1'b0) begin
            errors++; $display("FAIL garbage_done got done=%b err=%b want 1 0", ow_done, ow_err);
        end
        if (ow_core_rst !== 1'b0) begin errors++; $display("FAIL garbage_core_rst got %b want 0", ow_core_rst); end
    endtask

    task automatic test_basic();
        words[0] = 24'h123456;
        words[1] = 24'hABCDEF;
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        checks += 4;
        if (ow_done !== 1'b1)     begin errors++; $display("FAIL basic_done got %b want 1", ow_done); end
        if (ow_err !== 1'b0)      begin errors++; $display("FAIL basic_err got %b want 0", ow_err); end
        if (ow_core_rst !== 1'b0) begin errors++; $display("FAIL basic_core_rst got %b want 0", ow_core_rst); end
        if (exp_q.size() != 0)    begin errors++; $display("FAIL basic_writes got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_bad_csum();
        words[0] = 24'h123456;
        words[1] = 24'hABCDEF;
        send_byte(8'hA5);
        checks++;
        if (ow_core_rst !== 1'b1 || ow_done !== 1'b0) begin
            errors++; $display("FAIL restart_core_rst got core_rst=%b done=%b want 1 0", ow_core_rst, ow_done);
        end
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back({24'd0, 24'h123456});
        exp_q.push_back({24'd1, 24'hABCDEF});
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        send_byte(8'hF8);
        wait_end();
        checks += 4;
        if (ow_err !== 1'b1)      begin errors++; $display("FAIL badcsum_err got %b want 1", ow_err); end
        if (ow_done !== 1'b0)     begin errors++; $display("FAIL badcsum_done got %b want 0", ow_done); end
        if (ow_core_rst !== 1'b1) begin errors++; $display("FAIL badcsum_core_rst got %b want 1", ow_core_rst); end
        if (exp_q.size() != 0)    begin errors++; $display("FAIL badcsum_writes got %0d pending want 0", exp_q.size()); end
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        checks += 2;
        if (ow_done !== 1'b1 || ow_err !== 1'b0) begin
            errors++; $display("FAIL recover_done got done=%b err=%b want 1 0", ow_done, ow_err);
        end
        if (ow_core_rst !== 1'b0) begin errors++; $display("FAIL recover_core_rst got %b want 0", ow_core_rst); end
    endtask

    task automatic test_gap();
        words[0] = 24'h000001;
        words[1] = 24'hFFFFFF;
        words[2] = 24'hA5A5A5;
        send_frame(3, 1'b0, 1'b1);
        wait_end();
        checks += 2;
        if (ow_done !== 1'b1 || ow_err !== 1'b0) begin
            errors++; $display("FAIL gap_done got done=%b err=%b want 1 0", ow_done, ow_err);
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL gap_writes got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_midframe_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back({24'd0, 24'h111111});
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22);
        #2 iw_rst = 1'b1;
        #1;
        checks += 4;
        if (ow_mem_we !== 1'b0)    begin errors++; $display("FAIL abort_we got %b want 0", ow_mem_we); end
        if (ow_mem_addr !== 24'h0) begin errors++; $display("FAIL abort_addr got %h want 0", ow_mem_addr); end
        if (ow_core_rst !== 1'b1)  begin errors++; $display("FAIL abort_core_rst got %b want 1", ow_core_rst); end
        if (ow_done !== 1'b0 || ow_err !== 1'b0) begin
            errors++; $display("FAIL abort_status got done=%b err=%b want 0 0", ow_done, ow_err);
        end
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(negedge iw_clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_writes got %0d pending want 0", exp_q.size()); end
        words[0] = 24'hC0FFEE;
        words[1] = 24'h0BADF0;
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        checks += 2;
        if (ow_done !== 1'b1 || ow_err !== 1'b0) begin
            errors++; $display("FAIL reload_done got done=%b err=%b want 1 0", ow_done, ow_err);
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL reload_writes got %0d pending want 0", exp_q.size()); end
    endtask

`ifdef IMEM_LOADER_VERIFY_EN
    task automatic test_verify();
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            corrupt  = (pass == 0);
            words[0] = 24'h123456;
            words[1] = 24'hABCDEF;
            send_frame(2, 1'b0, 1'b0);
            cyc = 0;
            while (!ow_byte_ready && cyc < 20) begin
                checks++;
                if (ow_mem_we !== 1'b0) begin errors++; $display("FAIL verify_we got %b want 0", ow_mem_we); end
                cyc++;
                @(negedge iw_clk);
            end
            checks += 3;
            if (cyc != 3) begin errors++; $display("FAIL verify_cycles got %0d want 3", cyc); end
            if (corrupt) begin
                if (ow_err !== 1'b1 || ow_done !== 1'b0) begin
                    errors++; $display("FAIL verify_bad got done=%b err=%b want 0 1", ow_done, ow_err);
                end
                if (ow_core_rst !== 1'b1) begin errors++; $display("FAIL verify_bad_core_rst got %b want 1", ow_core_rst); end
            end else begin
                if (ow_done !== 1'b1 || ow_err !== 1'b0) begin
                    errors++; $display("FAIL verify_good got done=%b err=%b want 1 0", ow_done, ow_err);
                end
                if (ow_core_rst !== 1'b0) begin errors++; $display("FAIL verify_good_core_rst got %b want 0", ow_core_rst); end
            end
        end
        corrupt = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        corrupt       = 1'b0;
        we_prev       = 1'b0;
        iw_rst        = 1'b1;
        iw_byte_valid = 1'b0;
        iw_byte       = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 24'h0;
        @(negedge iw_clk);
        test_reset();
        test_garbage();
        test_basic();
        test_bad_csum();
        test_gap();
        test_midframe_reset();
`ifdef IMEM_LOADER_VERIFY_EN
        test_verify();
`endif
        repeat (3) @(negedge iw_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
